// File: rtl/gpio_input_conditioner.sv
// Multi-channel GPIO input conditioner: optional inversion, two-flop synchroniser,
// counter-based debounce, edge pulses and sticky event flags with a combined interrupt.
module gpio_input_conditioner #(
    parameter int                NUM_CH          = 5,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter logic [NUM_CH-1:0] INVERT          = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] i_raw,
    input  logic [NUM_CH-1:0] i_rise_en,
    input  logic [NUM_CH-1:0] i_fall_en,
    input  logic [NUM_CH-1:0] i_clr,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] o_event,
    output logic              o_irq
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] r_stable;
    logic [NUM_CH-1:0] r_rise;
    logic [NUM_CH-1:0] r_fall;
    logic [NUM_CH-1:0] r_event;
    logic [CW-1:0]     r_cnt [NUM_CH];

    logic [NUM_CH-1:0] w_diff;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_set;

    // A channel is accepted on the edge its counter has already seen
    // DEBOUNCE_CYCLES-1 consecutive differing cycles and the input still differs.
    always_comb begin
        w_diff   = r_sync2 ^ r_stable;
        w_accept = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_accept[n] = w_diff[n] && (r_cnt[n] == TERM);
        end
        w_set = (r_rise & i_rise_en) | (r_fall & i_fall_en);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_event  <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_cnt[n] <= '0;
            end
        end else begin
            r_sync1 <= i_raw ^ INVERT;
            r_sync2 <= r_sync1;
            for (int n = 0; n < NUM_CH; n++) begin
                if (!w_diff[n] || w_accept[n]) begin
                    r_cnt[n] <= '0;
                end else begin
                    r_cnt[n] <= r_cnt[n] + CW'(1);
                end
                if (w_accept[n]) begin
                    r_stable[n] <= r_sync2[n];
                end
            end
            r_rise  <= w_accept & r_sync2;
            r_fall  <= w_accept & ~r_sync2;
            // Set has priority over the write-1-to-clear strobe.
            r_event <= w_set | (r_event & ~i_clr);
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_event = r_event;
    assign o_irq   = |r_event;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed scenarios for the GPIO input conditioner; expected output vectors are
// queued when stimulus is applied and compared (under a mask) one edge at a time.
module tb_gpio_input_conditioner;

    localparam int W = 21;
    localparam logic [W-1:0] ALL = '1;

    logic       clk;
    logic       rstn;
    logic [4:0] i_raw, i_rise_en, i_fall_en, i_clr;
    logic [4:0] o_level, o_rise, o_fall, o_event;
    logic       o_irq;

    logic [4:0] i_raw2;
    logic [4:0] o_level2, o_rise2, o_fall2, o_event2;
    logic       o_irq2;

    logic [W-1:0] w_obs;
    assign w_obs = {o_level, o_rise, o_fall, o_event, o_irq};

    int total;
    int bad;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        tag_q[$];

    gpio_input_conditioner #(
        .NUM_CH(5), .DEBOUNCE_CYCLES(4), .INVERT(5'h00)
    ) u_dut (
        .clk(clk), .rstn(rstn), .i_raw(i_raw), .i_rise_en(i_rise_en),
        .i_fall_en(i_fall_en), .i_clr(i_clr), .o_level(o_level), .o_rise(o_rise),
        .o_fall(o_fall), .o_event(o_event), .o_irq(o_irq)
    );

    gpio_input_conditioner #(
        .NUM_CH(5), .DEBOUNCE_CYCLES(1), .INVERT(5'h01)
    ) u_dut_inv (
        .clk(clk), .rstn(rstn), .i_raw(i_raw2), .i_rise_en(5'h1F),
        .i_fall_en(5'h1F), .i_clr(5'h00), .o_level(o_level2), .o_rise(o_rise2),
        .o_fall(o_fall2), .o_event(o_event2), .o_irq(o_irq2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pk(input logic [4:0] lv, input logic [4:0] rs,
                                        input logic [4:0] fl, input logic [4:0] ev,
                                        input logic iq);
        return {lv, rs, fl, ev, iq};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // driver tasks
    task automatic push(input string tag, input logic [W-1:0] e, input logic [W-1:0] m);
        tag_q.push_back(tag);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    task automatic skip(input int n);
        repeat (n) push("-", '0, '0);
    endtask

    task automatic run(input int n);
        logic [W-1:0] e, m;
        string t;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                t = tag_q.pop_front();
                if (m != '0) chk(t, w_obs & m, e & m);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        i_raw     = 5'h1F;
        i_raw2    = 5'h01;
        i_rise_en = 5'h1F;
        i_fall_en = 5'h1F;
        i_clr     = 5'h00;

        // reset with all inputs high, then release
        repeat (3) push("rst_zero", '0, ALL);
        run(3);
        rstn = 1'b1;
        skip(4);
        push("rst_hold",   '0, pk(5'h1F, 5'h1F, 0, 0, 0));
        push("rst_accept", pk(5'h1F, 5'h1F, 0, 0, 0), ALL);
        push("rst_event",  pk(5'h1F, 0, 0, 5'h1F, 1), ALL);
        run(7);
        i_clr = 5'h1F;
        push("clr_all", '0, pk(0, 0, 0, 5'h1F, 1));
        run(1);
        i_clr = 5'h00;
        i_raw = 5'h00;
        skip(5);
        push("rel_all",   pk(0, 0, 5'h1F, 0, 0), ALL);
        push("rel_event", pk(0, 0, 0, 5'h1F, 1), ALL);
        run(7);
        i_clr = 5'h1F;
        push("clr_all2", '0, pk(0, 0, 0, 5'h1F, 1));
        run(1);
        i_clr = 5'h00;

        // clean press on ch0
        i_raw = 5'h01;
        skip(4);
        push("press_hold", '0, pk(1, 1, 0, 0, 0));
        push("press_acc",  pk(1, 1, 0, 0, 0), ALL);
        push("press_evt",  pk(1, 0, 0, 1, 1), ALL);
        run(7);
        i_clr = 5'h01;
        push("press_clr", pk(1, 0, 0, 0, 0), ALL);
        run(1);
        i_clr = 5'h00;

        // bounce on ch1: never held long enough
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) i_raw[1] = ~i_raw[1];
            push("bounce", '0, pk(5'h02, 5'h02, 5'h02, 5'h02, 1));
            run(1);
        end
        i_raw[1] = 1'b0;
        repeat (8) push("bounce_after", '0, pk(5'h02, 5'h02, 5'h02, 5'h02, 1));
        run(8);

        // ch2: set-vs-clear race
        i_fall_en = 5'h1B;
        i_raw[2]  = 1'b1;
        skip(5);
        push("c2_rise", pk(5'h04, 5'h04, 0, 0, 0), pk(5'h04, 5'h04, 5'h04, 5'h04, 0));
        push("c2_evt",  pk(5'h04, 0, 0, 5'h04, 1), pk(5'h04, 5'h04, 5'h04, 5'h04, 1));
        run(7);
        i_raw[2] = 1'b0;
        skip(5);
        push("c2_fall_masked", pk(0, 0, 5'h04, 5'h04, 1), pk(5'h04, 5'h04, 5'h04, 5'h04, 1));
        push("c2_hold",        pk(0, 0, 0, 5'h04, 1), pk(5'h04, 5'h04, 5'h04, 5'h04, 1));
        run(7);
        i_raw[2] = 1'b1;
        skip(5);
        push("c2_rise2", pk(5'h04, 5'h04, 0, 5'h04, 1), pk(5'h04, 5'h04, 5'h04, 5'h04, 1));
        run(6);
        i_clr = 5'h04;
        push("race_set_wins", pk(5'h04, 0, 0, 5'h04, 1), pk(5'h04, 5'h04, 5'h04, 5'h04, 1));
        run(1);
        push("clr_alone", pk(5'h04, 0, 0, 0, 0), pk(5'h04, 5'h04, 5'h04, 5'h1F, 1));
        run(1);
        i_clr     = 5'h00;
        i_fall_en = 5'h1F;

        // ch3: masked fall pulses but raises no event
        i_fall_en = 5'h17;
        i_raw[3]  = 1'b1;
        skip(6);
        push("c3_evt", pk(5'h08, 0, 0, 5'h08, 1), pk(5'h08, 5'h08, 5'h08, 5'h08, 1));
        run(7);
        i_clr = 5'h08;
        push("c3_clr", '0, pk(0, 0, 0, 5'h08, 1));
        run(1);
        i_clr    = 5'h00;
        i_raw[3] = 1'b0;
        skip(4);
        push("c3_pre",      pk(5'h08, 0, 0, 0, 0), pk(5'h08, 5'h08, 5'h08, 5'h08, 1));
        push("c3_fall",     pk(0, 0, 5'h08, 0, 0), pk(5'h08, 5'h08, 5'h08, 5'h08, 1));
        push("c3_fall_end", '0, pk(5'h08, 5'h08, 5'h08, 5'h08, 1));
        push("c3_no_evt",   '0, pk(5'h08, 5'h08, 5'h08, 5'h08, 1));
        run(8);
        i_fall_en = 5'h1F;

        // ch4: reset in the middle of a count
        i_raw[4] = 1'b1;
        skip(3);
        run(3);
        rstn = 1'b0;
        push("midrst", '0, ALL);
        run(1);
        rstn = 1'b1;
        skip(4);
        push("c4_hold", '0, pk(5'h10, 5'h10, 0, 0, 0));
        push("c4_acc",  pk(5'h15, 5'h15, 0, 0, 0), ALL);
        push("c4_evt",  pk(5'h15, 0, 0, 5'h15, 1), ALL);
        run(7);

        // inverted, single-cycle debounce instance
        chk("inv_idle", {o_level2, o_rise2, o_fall2, o_event2, o_irq2}, '0);
        i_raw2 = 5'h03;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("inv_e1", {27'd0, o_level2}, 32'h0);
        @(posedge clk); #1;
        chk("inv_acc", {22'd0, o_level2, o_rise2}, {22'd0, 5'h02, 5'h02});
        @(posedge clk); #1;
        chk("inv_evt", {21'd0, o_rise2, o_event2, o_irq2}, {21'd0, 5'h00, 5'h02, 1'b1});

        chk("sb_empty", exp_q.size(), 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 Parameter NUM_CH, default 5: number of independent input channels (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: clock cycles an input must stay stable before it is accepted (1..2^24-1; 10 ms at 50 MHz).
REQ-003 Parameter INVERT, default all zeros, NUM_CH bits: per-channel input polarity inversion, applied before synchronisation.
REQ-004 The counter width SHALL be derived as clog2(DEBOUNCE_CYCLES+1); no other width parameter exists.
REQ-005 clk  input  1: single clock; all logic on its rising edge.
REQ-006 rstn  input  1: synchronous, active-low reset.
REQ-007 i_raw  input  NUM_CH: asynchronous raw inputs (buttons, switches).
REQ-008 i_rise_en  input  NUM_CH: per-channel enable for rising-edge events.
REQ-009 i_fall_en  input  NUM_CH: per-channel enable for falling-edge events.
REQ-010 i_clr  input  NUM_CH: write-1-to-clear strobe for o_event bits.
REQ-011 o_level  output  NUM_CH: debounced level per channel.
REQ-012 o_rise  output  NUM_CH: one-cycle pulse on an accepted 0->1 transition.
REQ-013 o_fall  output  NUM_CH: one-cycle pulse on an accepted 1->0 transition.
REQ-014 o_event  output  NUM_CH: sticky event flags.
REQ-015 o_irq  output  1: OR-reduction of o_event.

Function
REQ-016 Each channel SHALL pass i_raw XOR INVERT through a two-flop synchroniser (sync1, sync2) before any other use.
REQ-017 Each channel SHALL hold a stable register (drives o_level) and a counter.
REQ-018 Counter, while sync2 == stable: cleared to 0.
REQ-019 Counter, while sync2 != stable and counter < DEBOUNCE_CYCLES-1: increments by 1 per cycle.
REQ-020 Acceptance: when sync2 != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL take sync2 at that edge and the counter SHALL clear.
REQ-021 Any single-cycle return of sync2 to stable SHALL restart the count from 0, so glitches shorter than DEBOUNCE_CYCLES cycles are never accepted.
REQ-022 Latency: a change on i_raw, set up before edge 0 and held, SHALL appear on o_level after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 rising edges counting edge 0.
REQ-023 o_rise/o_fall SHALL be registered and asserted for exactly one cycle, in the same cycle o_level first shows the new value.
REQ-024 o_event[n] SHALL set at the edge after (o_rise[n] & i_rise_en[n]) | (o_fall[n] & i_fall_en[n]) is sampled high.
REQ-025 o_event[n] SHALL clear at an edge where i_clr[n]=1 and no set condition is sampled.
REQ-026 Simultaneous set and clear on the same channel: set SHALL win (o_event stays/becomes 1).
REQ-027 o_event SHALL otherwise hold its value indefinitely; channels SHALL be fully independent.
REQ-028 o_irq SHALL be combinational from o_event, with no added latency.
REQ-029 Enable changes SHALL affect only subsequent pulses; already-set events are unaffected.
REQ-030 DEBOUNCE_CYCLES=1 SHALL accept any change held for one cycle after sync2 differs from stable (latency 3 edges).

Reset
REQ-031 While rstn=0 at an edge: sync1, sync2, stable, counters, o_rise, o_fall and o_event SHALL be 0; o_level=0 and o_irq=0.
REQ-032 Reset mid-count SHALL discard partial counts; after release, a held input SHALL need the full DEBOUNCE_CYCLES+2 edges again.
REQ-033 With INVERT[n]=1 and i_raw[n] idle high, o_level[n] SHALL stay 0 after reset with no pulse or event.

Verification (NUM_CH=5, DEBOUNCE_CYCLES=4, INVERT=0, enables all 1 unless stated)
REQ-034 Reset: rstn=0 for 3 cycles, i_raw=5'h1F -> all outputs 0 during reset; after release o_level=5'h1F after 6 edges, with one o_rise pulse per channel.
REQ-035 Clean press: i_raw[0] 0->1 held before edge 0 -> o_level[0]=1 and o_rise[0]=1 after edge 5; o_rise[0]=0 after edge 6; o_event[0]=1 and o_irq=1 after edge 6.
REQ-036 Bounce: i_raw[1] toggled every 3 cycles for 40 cycles -> o_level[1], o_rise[1] and o_event[1] stay 0.
REQ-037 Clear race: o_event[2]=1; i_clr[2]=1 in the same cycle a new rise event is sampled -> o_event[2] stays 1; i_clr[2]=1 alone next cycle -> o_event[2]=0, o_irq=0.
REQ-038 Mask: i_fall_en[3]=0; release ch3 after it is accepted high -> o_fall[3] pulses once, o_event[3] unchanged (0 after prior clear).
REQ-039 Reset mid-count: ch4 raw high for 3 cycles, rstn=0 one cycle, then release -> o_level[4]=1 only 6 edges after reset release.
